// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares one synchronous-read data memory between the CPU load/store port
//   and an external loader/debug port. Each granted transaction runs
//   IDLE -> ACC -> DONE: the access strobe is issued in ACC and the owner's
//   done pulse (plus load-data capture) happens in DONE.
//
//   Optional feature: define DM_ARB_ROUND_ROBIN_EN to alternate grants on
//   simultaneous requests. Without it the CPU always wins a tie.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request (held until cpu_done)
//   cpu_stall, cpu_done, cpu_rdata  CPU handshake and registered load data
//   ext_req/we/addr/wdata           external port request
//   ext_done, ext_rdata             external handshake and registered load data
//   dm_re, dm_we, dm_addr, dm_wdata memory strobes, address and write data
//   dm_rdata                        memory read data, one cycle after dm_re
module dm_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_done,
  output logic [DW-1:0] ext_rdata,
  output logic          dm_re,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  logic [1:0]    state_r, state_nxt_s;
  logic          owner_r, owner_nxt_s;
  logic          last_grant_r, last_grant_nxt_s;
  logic          we_r, we_nxt_s;
  logic [AW-1:0] addr_r, addr_nxt_s;
  logic [DW-1:0] wdata_r, wdata_nxt_s;
  logic          dm_re_r, dm_re_nxt_s;
  logic          dm_we_r, dm_we_nxt_s;
  logic          cpu_done_r, cpu_done_nxt_s;
  logic          ext_done_r, ext_done_nxt_s;
  logic [DW-1:0] cpu_rdata_r, cpu_rdata_nxt_s;
  logic [DW-1:0] ext_rdata_r, ext_rdata_nxt_s;

  logic          grant_s;
  logic          grant_owner_s;
  logic          prefer_ext_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  // Tie-break preference when both ports request in the same cycle.
  always_comb begin
`ifdef DM_ARB_ROUND_ROBIN_EN
    prefer_ext_s = (last_grant_r == OWN_CPU);
`else
    // Fixed CPU priority: last_grant is tracked but never steers the grant.
    prefer_ext_s = last_grant_r & 1'b0;
`endif
  end

  // Pick the winning requester and select its request fields.
  always_comb begin
    grant_s       = 1'b0;
    grant_owner_s = OWN_CPU;
    if (cpu_req && ext_req) begin
      grant_s       = 1'b1;
      grant_owner_s = prefer_ext_s ? OWN_EXT : OWN_CPU;
    end else if (ext_req) begin
      grant_s       = 1'b1;
      grant_owner_s = OWN_EXT;
    end else if (cpu_req) begin
      grant_s       = 1'b1;
      grant_owner_s = OWN_CPU;
    end else begin
      grant_s       = 1'b0;
      grant_owner_s = OWN_CPU;
    end

    if (grant_owner_s == OWN_EXT) begin
      sel_we_s    = ext_we;
      sel_addr_s  = ext_addr;
      sel_wdata_s = ext_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_ACC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for every registered output and latch.
  // Strobes and done pulses are computed one state early so that the
  // registered versions line up with ACC and DONE respectively.
  always_comb begin
    owner_nxt_s      = owner_r;
    last_grant_nxt_s = last_grant_r;
    we_nxt_s         = we_r;
    addr_nxt_s       = addr_r;
    wdata_nxt_s      = wdata_r;
    dm_re_nxt_s      = 1'b0;
    dm_we_nxt_s      = 1'b0;
    cpu_done_nxt_s   = 1'b0;
    ext_done_nxt_s   = 1'b0;
    cpu_rdata_nxt_s  = cpu_rdata_r;
    ext_rdata_nxt_s  = ext_rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          owner_nxt_s = grant_owner_s;
          we_nxt_s    = sel_we_s;
          addr_nxt_s  = sel_addr_s;
          wdata_nxt_s = sel_wdata_s;
          dm_we_nxt_s = sel_we_s;
          dm_re_nxt_s = ~sel_we_s;
        end else begin
          owner_nxt_s = owner_r;
        end
      end
      ST_ACC: begin
        cpu_done_nxt_s = (owner_r == OWN_CPU);
        ext_done_nxt_s = (owner_r == OWN_EXT);
      end
      ST_DONE: begin
        last_grant_nxt_s = owner_r;
        // Read data is valid during DONE because the strobe was in ACC.
        if (!we_r) begin
          if (owner_r == OWN_EXT) begin
            ext_rdata_nxt_s = dm_rdata;
          end else begin
            cpu_rdata_nxt_s = dm_rdata;
          end
        end else begin
          cpu_rdata_nxt_s = cpu_rdata_r;
        end
      end
      default: begin
        owner_nxt_s = owner_r;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_r      <= OWN_CPU;
      last_grant_r <= OWN_EXT;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      dm_re_r      <= 1'b0;
      dm_we_r      <= 1'b0;
      cpu_done_r   <= 1'b0;
      ext_done_r   <= 1'b0;
      cpu_rdata_r  <= '0;
      ext_rdata_r  <= '0;
    end else begin
      owner_r      <= owner_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      we_r         <= we_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      dm_re_r      <= dm_re_nxt_s;
      dm_we_r      <= dm_we_nxt_s;
      cpu_done_r   <= cpu_done_nxt_s;
      ext_done_r   <= ext_done_nxt_s;
      cpu_rdata_r  <= cpu_rdata_nxt_s;
      ext_rdata_r  <= ext_rdata_nxt_s;
    end
  end

  // Stall follows the live request so the CPU sees it in the request cycle;
  // it is forced low in reset and drops in the CPU's DONE cycle.
  assign cpu_stall = rstn & cpu_req & ~((state_r == ST_DONE) & (owner_r == OWN_CPU));

  assign cpu_done  = cpu_done_r;
  assign cpu_rdata = cpu_rdata_r;
  assign ext_done  = ext_done_r;
  assign ext_rdata = ext_rdata_r;
  assign dm_re     = dm_re_r;
  assign dm_we     = dm_we_r;
  assign dm_addr   = addr_r;
  assign dm_wdata  = wdata_r;

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cpu_req, cpu_we, ext_req, ext_we;
  logic [AW-1:0] cpu_addr, ext_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata;
  logic          cpu_stall, cpu_done, ext_done;
  logic [DW-1:0] cpu_rdata, ext_rdata;
  logic          dm_re, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata = 16'h0000;

  dm_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_done(ext_done), .ext_rdata(ext_rdata),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  initial forever #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Unwritten memory locations read back as 0x5A<addr>.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {8'h5A, a};
  endfunction

  // Memory responder: synchronous read, data valid the cycle after dm_re.
  logic [15:0] mem   [0:255];
  bit          mem_w [0:255];
  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_addr]   <= dm_wdata;
      mem_w[dm_addr] <= 1'b1;
    end
    if (dm_re) dm_rdata <= mem_w[dm_addr] ? mem[dm_addr] : init_val(dm_addr);
  end

  function automatic logic [15:0] mem_peek(input logic [7:0] a);
    return mem_w[a] ? mem[a] : init_val(a);
  endfunction

  // Timeline model: a grant at edge g puts the strobe in the cycle after g,
  // the done pulse one cycle later, updates rdata at edge g+2, and the
  // arbiter is free again at edge g+3.
  int          edge_cnt  = 0;
  int          g         = 0;
  int          free_edge = 0;
  bit          act       = 1'b0;
  bit          lg        = 1'b1;   // 0 = CPU, 1 = EXT
  bit          t_owner   = 1'b0;
  bit          t_we      = 1'b0;
  logic [7:0]  t_addr    = 8'h00;
  logic [15:0] t_wdata   = 16'h0000;
  logic [15:0] rd_val    = 16'h0000;
  logic [7:0]  exp_addr  = 8'h00;
  logic [15:0] exp_wdata = 16'h0000;
  logic [15:0] exp_cpu_rdata = 16'h0000;
  logic [15:0] exp_ext_rdata = 16'h0000;
  logic [15:0] ref_mem [0:255];
  bit          ref_w   [0:255];

  always @(posedge clk or negedge rstn) begin : model_blk
    if (!rstn) begin
      act = 1'b0; lg = 1'b1; free_edge = 0; edge_cnt = 0;
      exp_addr = 8'h00; exp_wdata = 16'h0000;
      exp_cpu_rdata = 16'h0000; exp_ext_rdata = 16'h0000;
    end else begin
      edge_cnt++;
      if (act && edge_cnt == g + 1) begin
        if (t_we) begin
          ref_mem[t_addr] = t_wdata;
          ref_w[t_addr]   = 1'b1;
        end else begin
          rd_val = ref_w[t_addr] ? ref_mem[t_addr] : init_val(t_addr);
        end
      end
      if (act && edge_cnt == g + 2) begin
        if (!t_we) begin
          if (t_owner) exp_ext_rdata = rd_val;
          else         exp_cpu_rdata = rd_val;
        end
        lg  = t_owner;
        act = 1'b0;
      end
      if (edge_cnt >= free_edge && (cpu_req || ext_req)) begin
        if (cpu_req && ext_req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
          t_owner = ~lg;
`else
          t_owner = 1'b0;
`endif
        end else begin
          t_owner = ext_req;
        end
        t_we      = t_owner ? ext_we    : cpu_we;
        t_addr    = t_owner ? ext_addr  : cpu_addr;
        t_wdata   = t_owner ? ext_wdata : cpu_wdata;
        exp_addr  = t_addr;
        exp_wdata = t_wdata;
        g         = edge_cnt;
        free_edge = edge_cnt + 3;
        act       = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, plus logs of completed grants
  // and of read strobes for the directed checks.
  int neg_cyc = 0;
  bit grant_log [$];
  int re_times  [$];
  always @(negedge clk) begin : cmp_blk
    bit strobe_v, done_v, exp_cd, exp_ed;
    neg_cyc++;
    strobe_v = act && (edge_cnt == g);
    done_v   = act && (edge_cnt == g + 1);
    exp_cd   = done_v && !t_owner;
    exp_ed   = done_v && t_owner;
    chk("dm_re",      32'(dm_re),     32'(strobe_v && !t_we));
    chk("dm_we",      32'(dm_we),     32'(strobe_v && t_we));
    chk("re_we_excl", 32'(dm_re & dm_we), 32'd0);
    chk("dm_addr",    32'(dm_addr),   32'(exp_addr));
    chk("dm_wdata",   32'(dm_wdata),  32'(exp_wdata));
    chk("cpu_done",   32'(cpu_done),  32'(exp_cd));
    chk("ext_done",   32'(ext_done),  32'(exp_ed));
    chk("cpu_stall",  32'(cpu_stall), 32'(rstn && cpu_req && !exp_cd));
    chk("cpu_rdata",  32'(cpu_rdata), 32'(exp_cpu_rdata));
    chk("ext_rdata",  32'(ext_rdata), 32'(exp_ext_rdata));
    if (cpu_done) grant_log.push_back(1'b0);
    if (ext_done) grant_log.push_back(1'b1);
    if (dm_re)    re_times.push_back(neg_cyc);
  end

  initial begin : stim
    logic [3:0] exp_seq;
    int base;
    rstn = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dm_re", 32'(dm_re), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    step(); rstn = 1'b1;

    // Both requesters held for four grants.
`ifdef DM_ARB_ROUND_ROBIN_EN
    exp_seq = 4'b1010;  // bit i = owner of grant i (0 CPU, 1 EXT)
`else
    exp_seq = 4'b0000;
`endif
    grant_log.delete();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h30;
    repeat (12) step();
    cpu_req = 1'b0; ext_req = 1'b0;
    repeat (3) step();
    chk("arb_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size())
        chk($sformatf("arb_grant%0d", i), 32'(grant_log[i]), 32'(exp_seq[i]));
    end
    chk("arb_cpu_rdata", 32'(cpu_rdata), 32'h5A20);
`ifdef DM_ARB_ROUND_ROBIN_EN
    chk("arb_ext_rdata", 32'(ext_rdata), 32'h5A30);
`else
    chk("arb_ext_rdata", 32'(ext_rdata), 32'h0000);
`endif

    // CPU store 0x12 <- 0xBEEF.
    step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h12; cpu_wdata = 16'hBEEF;
    step(); @(negedge clk);
    chk("st_dm_we", 32'(dm_we), 32'd1);
    chk("st_dm_addr", 32'(dm_addr), 32'h12);
    chk("st_dm_wdata", 32'(dm_wdata), 32'hBEEF);
    chk("st_stall_acc", 32'(cpu_stall), 32'd1);
    step(); @(negedge clk);
    chk("st_done", 32'(cpu_done), 32'd1);
    chk("st_stall_done", 32'(cpu_stall), 32'd0);
    step(); cpu_req = 1'b0; @(negedge clk);
    chk("st_addr_hold", 32'(dm_addr), 32'h12);

    // EXT load 0x12.
    step(); ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h12;
    step(); @(negedge clk);
    chk("ld_dm_re", 32'(dm_re), 32'd1);
    step(); @(negedge clk);
    chk("ld_ext_done", 32'(ext_done), 32'd1);
    step(); ext_req = 1'b0; @(negedge clk);
    chk("ld_ext_rdata", 32'(ext_rdata), 32'hBEEF);
    chk("ld_cpu_rdata", 32'(cpu_rdata), 32'h5A20);

    // CPU load 0x05 with request dropped in the strobe cycle.
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    base = re_times.size();
    step(); cpu_req = 1'b0; @(negedge clk);
    chk("drop_dm_re", 32'(dm_re), 32'd1);
    step(); @(negedge clk);
    chk("drop_done", 32'(cpu_done), 32'd1);
    repeat (4) step();
    chk("drop_re_count", 32'(re_times.size() - base), 32'd1);
    chk("drop_rdata", 32'(cpu_rdata), 32'h5A05);

    // Reset during the ACC cycle of a CPU store to 0x40.
    step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'h1234;
    step(); rstn = 1'b0; @(negedge clk);
    chk("rst_mid_we", 32'(dm_we), 32'd0);
    chk("rst_mid_stall", 32'(cpu_stall), 32'd0);
    chk("rst_mid_addr", 32'(dm_addr), 32'd0);
    chk("rst_mid_ext_rdata", 32'(ext_rdata), 32'd0);
    step(); step(); rstn = 1'b1; @(negedge clk);
    chk("rst_mem_kept", 32'(mem_peek(8'h40)), 32'h5A40);
    step(); @(negedge clk);
    chk("regrant_we", 32'(dm_we), 32'd1);
    chk("regrant_addr", 32'(dm_addr), 32'h40);
    chk("regrant_wdata", 32'(dm_wdata), 32'h1234);
    step(); @(negedge clk);
    chk("regrant_done", 32'(cpu_done), 32'd1);
    step(); cpu_req = 1'b0;
    step();
    chk("regrant_mem", 32'(mem_peek(8'h40)), 32'h1234);

    // Back-to-back CPU loads with request held.
    step(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h07;
    base = re_times.size();
    repeat (9) step();
    cpu_req = 1'b0;
    repeat (3) step();
    chk("b2b_re_count", 32'(re_times.size() - base), 32'd3);
    if (re_times.size() >= base + 3) begin
      chk("b2b_gap0", 32'(re_times[base + 1] - re_times[base]), 32'd3);
      chk("b2b_gap1", 32'(re_times[base + 2] - re_times[base + 1]), 32'd3);
    end
    chk("b2b_rdata", 32'(cpu_rdata), 32'h5A07);

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

Interface
REQ-001 Parameter AW, default 8: data-memory address width.
REQ-002 Parameter DW, default 16: data word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  CPU load/store request; held high until cpu_done.
REQ-006 cpu_we  input  1  1 = store, 0 = load.
REQ-007 cpu_addr  input  AW  CPU address.
REQ-008 cpu_wdata  input  DW  CPU store data.
REQ-009 cpu_stall  output  1  high while cpu_req is high and its transaction has not reached DONE.
REQ-010 cpu_done  output  1  one-cycle completion pulse for a CPU transaction.
REQ-011 cpu_rdata  output  DW  registered load data for the CPU.
REQ-012 ext_req, ext_we, ext_addr (AW), ext_wdata (DW)  inputs  external loader/debug port, same meaning as the CPU inputs.
REQ-013 ext_done  output  1  completion pulse; ext_rdata  output  DW  registered load data.
REQ-014 dm_re, dm_we  outputs  1  memory read/write strobes; dm_addr  output  AW; dm_wdata  output  DW.
REQ-015 dm_rdata  input  DW  memory read data, valid one cycle after dm_re (synchronous read).

Function
REQ-016 FSM states are IDLE, ACC and DONE, plus a 1-bit owner register (CPU/EXT) and a 1-bit last_grant register.
REQ-017 IDLE with no request: stay in IDLE, all dm_* strobes low.
REQ-018 IDLE with exactly one request: grant it; latch we, addr and wdata into internal registers; set owner; go to ACC.
REQ-019 IDLE with both requests: arbitrate per REQ-031/REQ-032; the loser waits; its stall/handshake outputs are unaffected.
REQ-020 ACC, one cycle: drive dm_addr and dm_wdata from the latched registers; assert dm_we (store) or dm_re (load) for exactly this cycle; go to DONE.
REQ-021 DONE, one cycle: assert done for the owner only; for a load, capture dm_rdata into the owner's rdata register; update last_grant to owner; go to IDLE.
REQ-022 Latency: the request sampled in IDLE at edge N produces the strobe in cycle N+1 and the done pulse in cycle N+2; the minimum request-to-request period is 3 cycles.
REQ-023 A store leaves the owner's rdata register unchanged; the non-owner's rdata never changes.
REQ-024 A request deasserted during ACC or DONE does not abort the transaction; it completes and done still pulses.
REQ-025 A requester that keeps req high after its done pulse is treated as a new transaction when the FSM is next in IDLE.
REQ-026 Outside ACC, dm_re = dm_we = 0; dm_addr and dm_wdata hold their last latched values.
REQ-027 dm_re and dm_we are never high together; at most one memory access is issued per transaction.

Reset
REQ-028 While rstn = 0: state = IDLE; last_grant = EXT; owner = CPU; all dm_* outputs, done pulses, cpu_rdata and ext_rdata = 0.
REQ-029 Reset asserted mid-transaction abandons it: no strobe and no done pulse is issued for it after release.
REQ-030 The first edge after release evaluates requests as in IDLE.

Configuration
REQ-031 With DM_ARB_ROUND_ROBIN_EN defined, simultaneous requests are granted to the requester that is not last_grant (alternating).
REQ-032 Without DM_ARB_ROUND_ROBIN_EN, simultaneous requests are always granted to the CPU; last_grant is still maintained but unused.

Verification
REQ-033 CPU store addr 0x12, data 0xBEEF, ext idle -> dm_we high for one cycle, 1 cycle after the request edge, with dm_addr = 0x12 and dm_wdata = 0xBEEF; cpu_done pulses 1 cycle later; cpu_stall drops with done.
REQ-034 EXT load addr 0x12, memory model returns 0xBEEF -> ext_done pulses with ext_rdata = 0xBEEF; cpu_rdata is unchanged.
REQ-035 Both requesters held high for 4 transactions -> with the macro: grant order CPU, EXT, CPU, EXT; without it: CPU on every grant while cpu_req stays high.
REQ-036 rstn pulsed low during ACC of a CPU store -> no cpu_done pulse; all outputs 0 during reset; next grant after release behaves per REQ-018.
REQ-037 cpu_req dropped during ACC of a load -> dm_re is still issued once and cpu_done still pulses; no second access occurs.
REQ-038 Back-to-back CPU loads with req held continuously -> exactly one dm_re every 3 cycles; dm_re and dm_we are never asserted together.
